sti_dac_gen: RTL and testbench

Parametrised serial-transmit / DAC-pack engine, the next generation of the STI_DAC block.
- Accepts a parallel word with format controls and emits a serial frame on so_data/so_valid.
- Packs the same bit stream into PW-bit pixels and writes them to the pixel memory interface.
- On pi_end, zero-fills the remaining pixel addresses, then raises pixel_finish.
- New versus the previous block: generic widths and depth, a pi_ready handshake, and a sticky overflow flag.

---
 rtl/sti_dac_pkg.sv | 26 ++
 rtl/sti_dac_gen_if.sv | 39 +++
 rtl/sti_dac_pack.sv | 51 +++++
 rtl/sti_dac_gen.sv | 152 +++++++++++++++
 tb/tb_sti_dac_gen.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sti_dac_pkg.sv
// sti_dac_pkg: shared types, length codes and sizing helpers
// for the serial-transmit / pixel-pack engine.
package sti_dac_pkg;

  localparam logic [1:0] LEN_HALF  = 2'b00;
  localparam logic [1:0] LEN_FULL  = 2'b01;
  localparam logic [1:0] LEN_3HALF = 2'b10;
  localparam logic [1:0] LEN_DBL   = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FILL,
    DONE
  } state_e;

  function automatic int frame_bits(int dw, logic [1:0] code);
    return (int'(code) + 1) * (dw / 2);
  endfunction

  // Bit counter must reach 2*DW, one past the longest frame.
  function automatic int cnt_w(int dw);
    return $clog2(2 * dw + 1);
  endfunction

endpackage

// File: rtl/sti_dac_gen_if.sv
// sti_dac_gen_if: frame request, serial out and pixel memory
// signals of sti_dac_gen, with master/slave views.
interface sti_dac_gen_if #(
  parameter int DW = 16,
  parameter int PW = 8,
  parameter int AW = 8
);
  logic          load;
  logic [DW-1:0] pi_data;
  logic [1:0]    pi_length;
  logic          pi_fill;
  logic          pi_msb;
  logic          pi_low;
  logic          pi_end;
  logic          pi_ready;
  logic          so_data;
  logic          so_valid;
  logic          pixel_wr;
  logic [AW-1:0] pixel_addr;
  logic [PW-1:0] pixel_dataout;
  logic          pixel_finish;
  logic          pixel_ovf;

  modport master (
    output load, pi_data, pi_length,
    output pi_fill, pi_msb, pi_low, pi_end,
    input  pi_ready, so_data, so_valid,
    input  pixel_wr, pixel_addr, pixel_dataout,
    input  pixel_finish, pixel_ovf
  );

  modport slave (
    input  load, pi_data, pi_length,
    input  pi_fill, pi_msb, pi_low, pi_end,
    output pi_ready, so_data, so_valid,
    output pixel_wr, pixel_addr, pixel_dataout,
    output pixel_finish, pixel_ovf
  );
endinterface

// File: rtl/sti_dac_pack.sv
// sti_dac_pack: collects serial bits MSB-first into PW-bit words
// and pulses wr_req the cycle after each word completes.
module sti_dac_pack #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          bit_vld,
  input  logic          bit_in,
  output logic          wr_req,
  output logic [PW-1:0] word
);
  localparam int GW = (PW > 1) ? $clog2(PW) : 1;

  logic [PW-1:0] sr_q, sr_d;
  logic [GW-1:0] grp_q, grp_d;
  logic          wr_q, wr_d;

  always_comb begin
    sr_d  = sr_q;
    grp_d = grp_q;
    wr_d  = 1'b0;
    if (bit_vld) begin
      sr_d = {sr_q[PW-2:0], bit_in};
      if (grp_q == GW'(PW - 1)) begin
        grp_d = '0;
        wr_d  = 1'b1;
      end else begin
        grp_d = grp_q + GW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sr_q  <= '0;
      grp_q <= '0;
      wr_q  <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      grp_q <= grp_d;
      wr_q  <= wr_d;
    end
  end

  // The next bit only lands at the end of the write cycle,
  // so sr_q still holds the finished word while wr_req is high.
  assign wr_req = wr_q;
  assign word   = sr_q;

endmodule

// File: rtl/sti_dac_gen.sv
// sti_dac_gen: frames shift out on so_*, and the same bits pack
// into PW-bit pixel writes; pi_end zero-fills the rest of memory.
module sti_dac_gen
  import sti_dac_pkg::*;
#(
  parameter int DW = 16,
  parameter int PW = 8,
  parameter int AW = 8
) (
  input logic          clk,
  input logic          reset,
  sti_dac_gen_if.slave bus
);
  localparam int FW = 2 * DW;
  localparam int CW = cnt_w(DW);

  state_e        state_q, state_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] fb_q, fb_d;
  logic          msb_q, msb_d;
  logic          end_q, end_d;
  logic [AW:0]   addr_q, addr_d;
  logic          ovf_q, ovf_d;

  logic [FW-1:0] ld_word;
  logic [CW-1:0] ld_fb;
  logic          so_valid;
  logic          so_data;
  logic          pk_wr;
  logic [PW-1:0] pk_word;
  logic          wr;

  always_comb begin
    ld_word = '0;
    unique case (bus.pi_length)
      LEN_HALF: begin
        if (bus.pi_low) ld_word[DW/2-1:0] = bus.pi_data[DW-1:DW/2];
        else            ld_word[DW/2-1:0] = bus.pi_data[DW/2-1:0];
      end
      LEN_FULL: ld_word[DW-1:0] = bus.pi_data;
      LEN_3HALF: begin
        if (bus.pi_fill) ld_word[3*DW/2-1:DW/2] = bus.pi_data;
        else             ld_word[DW-1:0]        = bus.pi_data;
      end
      LEN_DBL: begin
        if (bus.pi_fill) ld_word[FW-1:DW] = bus.pi_data;
        else             ld_word[DW-1:0]  = bus.pi_data;
      end
    endcase
    ld_fb = CW'(frame_bits(DW, bus.pi_length));
    // MSB-first frames are left-aligned so both orders shift out of an end bit.
    if (bus.pi_msb)
      ld_word = ld_word << (FW - frame_bits(DW, bus.pi_length));
  end

  assign so_valid = (state_q == SHIFT) && (cnt_q != fb_q);
  assign so_data  = so_valid & (msb_q ? frame_q[FW-1] : frame_q[0]);

  sti_dac_pack #(.PW(PW)) u_pack (
    .clk     (clk),
    .reset   (reset),
    .bit_vld (so_valid),
    .bit_in  (so_data),
    .wr_req  (pk_wr),
    .word    (pk_word)
  );

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    cnt_d   = cnt_q;
    fb_d    = fb_q;
    msb_d   = msb_q;
    end_d   = end_q;
    addr_d  = addr_q;
    ovf_d   = ovf_q;
    wr      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.load) begin
          frame_d = ld_word;
          fb_d    = ld_fb;
          msb_d   = bus.pi_msb;
          end_d   = bus.pi_end;
          cnt_d   = '0;
          state_d = SHIFT;
        end else if (bus.pi_end) begin
          state_d = FILL;
        end
      end
      SHIFT: begin
        if (so_valid) begin
          cnt_d   = cnt_q + CW'(1);
          frame_d = msb_q ? (frame_q << 1) : (frame_q >> 1);
        end else begin
          cnt_d   = '0;
          state_d = end_q ? FILL : IDLE;
        end
      end
      FILL: begin
        if (addr_q[AW]) begin
          state_d = DONE;
        end else begin
          wr     = 1'b1;
          addr_d = addr_q + (AW+1)'(1);
        end
      end
      DONE: state_d = DONE;
    endcase
    if (pk_wr) begin
      if (!addr_q[AW]) begin
        wr     = 1'b1;
        addr_d = addr_q + (AW+1)'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      frame_q <= '0;
      cnt_q   <= '0;
      fb_q    <= '0;
      msb_q   <= 1'b0;
      end_q   <= 1'b0;
      addr_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      cnt_q   <= cnt_d;
      fb_q    <= fb_d;
      msb_q   <= msb_d;
      end_q   <= end_d;
      addr_q  <= addr_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.pi_ready      = (state_q == IDLE);
  assign bus.so_valid      = so_valid;
  assign bus.so_data       = so_data;
  assign bus.pixel_wr      = wr;
  assign bus.pixel_addr    = addr_q[AW-1:0];
  assign bus.pixel_dataout = pk_wr ? pk_word : '0;
  assign bus.pixel_finish  = (state_q == DONE);
  assign bus.pixel_ovf     = ovf_q;

endmodule

// File: tb/tb_sti_dac_gen.sv
// tb_sti_dac_gen: directed and randomized frames checked against
// a bit-list / pixel-list model of the frame rules.
`timescale 1ns/1ps
module tb_sti_dac_gen;
  localparam int DW   = 16;
  localparam int PW   = 8;
  localparam int AW   = 8;
  localparam int NPIX = 256;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  sti_dac_gen_if #(.DW(DW), .PW(PW), .AW(AW)) bus ();

  sti_dac_gen #(.DW(DW), .PW(PW), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int m_addr = 0;
  logic m_ovf = 1'b0;
  logic [7:0] obs_wd[$];
  int obs_wa[$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    bus.load = 1'b0;
    bus.pi_data = '0;
    bus.pi_length = 2'b00;
    bus.pi_fill = 1'b0;
    bus.pi_msb = 1'b0;
    bus.pi_low = 1'b0;
    bus.pi_end = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    idle_in();
    @(negedge clk);
    chk("rst_ready", bus.pi_ready, 1);
    chk("rst_so_data", bus.so_data, 0);
    chk("rst_so_valid", bus.so_valid, 0);
    chk("rst_wr", bus.pixel_wr, 0);
    chk("rst_addr", bus.pixel_addr, 0);
    chk("rst_dout", bus.pixel_dataout, 0);
    chk("rst_finish", bus.pixel_finish, 0);
    chk("rst_ovf", bus.pixel_ovf, 0);
    reset = 1'b1;
    m_addr = 0;
    m_ovf = 1'b0;
  endtask

  task automatic run_frame(input logic [15:0] d, input logic [1:0] len,
                           input logic fill, input logic msb,
                           input logic low, input logic endf);
    int fb;
    int n;
    logic [63:0] fv;
    logic [7:0] pix;
    logic b;
    logic q_bit[$];
    int q_wa[$];
    logic [7:0] q_wd[$];
    int q_wc[$];
    fb = (int'(len) + 1) * DW / 2;
    case (len)
      2'b00: fv = low ? 64'(d >> 8) : 64'(d & 16'h00FF);
      2'b01: fv = 64'(d);
      default: fv = fill ? (64'(d) << (fb - DW)) : 64'(d);
    endcase
    pix = '0;
    for (int i = 0; i < fb; i++) begin
      b = msb ? fv[fb-1-i] : fv[i];
      q_bit.push_back(b);
      pix = {pix[6:0], b};
      if (i % PW == PW - 1) begin
        if (m_addr < NPIX) begin
          q_wa.push_back(m_addr);
          q_wd.push_back(pix);
          q_wc.push_back(i + 2);
          m_addr++;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    n = 0;
    while (bus.pi_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", bus.pi_ready, 1);
    bus.pi_data = d;
    bus.pi_length = len;
    bus.pi_fill = fill;
    bus.pi_msb = msb;
    bus.pi_low = low;
    bus.pi_end = endf;
    bus.load = 1'b1;
    for (int c = 1; c <= fb + 1; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("busy", bus.pi_ready, 0);
        bus.pi_end = 1'b0;
      end
      // a load while busy must not disturb the frame in flight
      bus.load = (c == 2);
      chk("so_valid", bus.so_valid, 64'(c <= fb));
      if (c <= fb) chk("so_data", bus.so_data, q_bit[c-1]);
      if (q_wc.size() > 0 && q_wc[0] == c) begin
        chk("pix_wr", bus.pixel_wr, 1);
        chk("pix_addr", bus.pixel_addr, q_wa[0]);
        chk("pix_data", bus.pixel_dataout, q_wd[0]);
        obs_wd.push_back(bus.pixel_dataout);
        obs_wa.push_back(int'(bus.pixel_addr));
        void'(q_wc.pop_front());
        void'(q_wa.pop_front());
        void'(q_wd.pop_front());
      end else begin
        chk("pix_wr_idle", bus.pixel_wr, 0);
      end
    end
    bus.load = 1'b0;
    chk("writes_left", q_wc.size(), 0);
    if (!endf) begin
      @(negedge clk);
      chk("ready_back", bus.pi_ready, 1);
      chk("pix_ovf", bus.pixel_ovf, m_ovf);
    end
  endtask

  task automatic check_fill();
    int n;
    for (int a = m_addr; a < NPIX; a++) begin
      @(negedge clk);
      chk("fill_wr", bus.pixel_wr, 1);
      chk("fill_addr", bus.pixel_addr, a);
      chk("fill_data", bus.pixel_dataout, 0);
    end
    m_addr = NPIX;
    n = 0;
    do begin
      @(negedge clk);
      chk("fill_stop", bus.pixel_wr, 0);
      n++;
    end while (bus.pixel_finish !== 1'b1 && n < 4);
    chk("finish", bus.pixel_finish, 1);
    chk("done_ready", bus.pi_ready, 0);
    chk("done_ovf", bus.pixel_ovf, m_ovf);
    bus.pi_end = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic any;
    idle_in();
    repeat (2) @(negedge clk);
    do_reset();

    run_frame(16'hA5C3, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("tp1_data", obs_wd[0], 8'hC3);
    chk("tp1_addr", obs_wa[0], 0);
    run_frame(16'h1234, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("tp2_data", {obs_wd[1], obs_wd[2]}, 16'h2C48);
    chk("tp2_addr", obs_wa[2], 2);
    run_frame(16'hBEEF, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("tp3_fill1", {obs_wd[3], obs_wd[4], obs_wd[5]}, 24'hBEEF00);
    run_frame(16'hBEEF, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("tp3_fill0", {obs_wd[6], obs_wd[7], obs_wd[8]}, 24'h00BEEF);
    run_frame(16'h8001, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("tp4", {obs_wd[9], obs_wd[10], obs_wd[11], obs_wd[12]},
        32'h80010000);

    for (int k = 0; k < 12; k++)
      run_frame(16'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
                1'($urandom), 1'($urandom), 1'b0);

    @(negedge clk);
    bus.pi_data = 16'hFFFF;
    bus.pi_length = 2'b11;
    bus.pi_msb = 1'b1;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    repeat (9) @(negedge clk);
    chk("midframe_valid", bus.so_valid, 1);
    do_reset();

    obs_wa.delete();
    run_frame(16'($urandom), 2'b00, 1'b0, 1'($urandom), 1'($urandom), 1'b0);
    chk("post_rst_addr", obs_wa[0], 0);
    run_frame(16'($urandom), 2'b01, 1'b0, 1'($urandom), 1'b0, 1'b0);
    bus.pi_end = 1'b1;
    check_fill();

    any = 1'b0;
    bus.pi_data = 16'hFFFF;
    bus.pi_length = 2'b01;
    bus.load = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      bus.load = 1'b0;
      any = any | bus.so_valid | bus.pixel_wr;
    end
    chk("done_ignore", any, 0);
    chk("done_hold", bus.pixel_finish, 1);

    do_reset();
    obs_wa.delete();
    for (int k = 0; k < 129; k++)
      run_frame(16'($urandom), 2'b01, 1'b0, 1'($urandom), 1'b0, 1'b0);
    chk("ovf_flag", bus.pixel_ovf, 1);
    chk("ovf_wr_count", obs_wa.size(), 256);
    chk("ovf_last_addr", obs_wa[255], 255);
    bus.pi_end = 1'b1;
    check_fill();

    do_reset();
    for (int k = 0; k < 2; k++)
      run_frame(16'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
                1'($urandom), 1'($urandom), 1'b0);
    run_frame(16'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
              1'($urandom), 1'($urandom), 1'b1);
    check_fill();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
